i2c_slave_regs: RTL

Parametrised I2C target with an on-chip 8-bit register bank and auto-incrementing register pointer. It supports full write and read transfers, repeated START, and a configurable address and bank depth, and it filters glitches on SCL/SDA. It sits between the GPIO I2C pins and user logic: the host reads the bank through a side port and receives a strobe for every byte the bus master writes.

---
 rtl/i2c_slave_regs.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/i2c_slave_regs.sv
`timescale 1ns/1ps
// I2C target with an auto-incrementing 8-bit register bank, glitch-filtered SCL/SDA inputs,
// a combinational host read port and a strobe for every byte the bus master writes.
module i2c_slave_regs #(
    parameter logic [6:0] SLAVE_ADDR = 7'h36,
    parameter int         NUM_REGS   = 16,
    parameter int         FILTER_LEN = 3,
    localparam int        PTR_W      = ($clog2(NUM_REGS) < 1) ? 1 : $clog2(NUM_REGS)
) (
    input  logic             sysclk,
    input  logic             rst,
    input  logic             scl_i,
    input  logic             sda_i,
    output logic             sda_oe,
    input  logic [PTR_W-1:0] host_addr,
    output logic [7:0]       host_data,
    output logic             wr_valid,
    output logic [PTR_W-1:0] wr_addr,
    output logic [7:0]       wr_data,
    output logic             busy
);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
        S_WRITE, S_WR_ACK, S_READ, S_RD_ACK, S_IGNORE
    } state_t;

    // Index 1 carries SCL, index 0 carries SDA.
    logic [1:0] sync1, sync2, filt, filt_d;
    logic [3:0] cnt [2];

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            sync1  <= 2'b11;
            sync2  <= 2'b11;
            filt   <= 2'b11;
            filt_d <= 2'b11;
            cnt[0] <= '0;
            cnt[1] <= '0;
        end else begin
            sync1  <= {scl_i, sda_i};
            sync2  <= sync1;
            filt_d <= filt;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == 4'(FILTER_LEN - 1)) begin
                    filt[i] <= sync2[i];
                    cnt[i]  <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 4'd1;
                end
            end
        end
    end

    logic fscl, fsda, fscl_d, fsda_d;
    logic scl_rise, scl_fall, start_det, stop_det;

    assign fscl      = filt[1];
    assign fsda      = filt[0];
    assign fscl_d    = filt_d[1];
    assign fsda_d    = filt_d[0];
    assign scl_rise  = fscl & ~fscl_d;
    assign scl_fall  = ~fscl & fscl_d;
    assign start_det = fscl & fscl_d & fsda_d & ~fsda;
    assign stop_det  = fscl & fscl_d & ~fsda_d & fsda;

    state_t           state;
    logic [3:0]       bit_cnt;
    logic [6:0]       rx_sh;
    logic [7:0]       tx_sh;
    logic             rw;
    logic             ack_phase;
    logic             rd_more;
    logic [PTR_W-1:0] ptr;
    logic [7:0]       bank [NUM_REGS];

    logic [7:0]       rx_byte;
    logic [PTR_W-1:0] ptr_inc;

    // The completed byte is valid in the same cycle its 8th rising SCL is seen.
    assign rx_byte = {rx_sh, fsda};
    assign ptr_inc = (ptr == PTR_W'(NUM_REGS - 1)) ? '0 : ptr + PTR_W'(1);

    always_ff @(posedge sysclk) begin
        if (rst) begin
            state     <= S_IDLE;
            bit_cnt   <= '0;
            rx_sh     <= '0;
            tx_sh     <= '0;
            rw        <= 1'b0;
            ack_phase <= 1'b0;
            rd_more   <= 1'b0;
            ptr       <= '0;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            wr_valid  <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            // NOTE: the bank is cleared by reset, so it maps to flops rather than a RAM macro.
            for (int i = 0; i < NUM_REGS; i++) bank[i] <= '0;
        end else begin
            wr_valid <= 1'b0;
            if (stop_det) begin
                state  <= S_IDLE;
                sda_oe <= 1'b0;
                busy   <= 1'b0;
            end else if (start_det) begin
                state   <= S_ADDR;
                bit_cnt <= '0;
                sda_oe  <= 1'b0;
            end else begin
                case (state)
                    S_ADDR, S_PTR, S_WRITE: begin
                        if (scl_rise) begin
                            rx_sh   <= rx_byte[6:0];
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                bit_cnt   <= '0;
                                ack_phase <= 1'b0;
                                if (state == S_ADDR) begin
                                    if (rx_byte[7:1] == SLAVE_ADDR) begin
                                        rw    <= rx_byte[0];
                                        busy  <= 1'b1;
                                        state <= S_ADDR_ACK;
                                    end else begin
                                        busy  <= 1'b0;
                                        state <= S_IGNORE;
                                    end
                                end else if (state == S_PTR) begin
                                    if ({1'b0, rx_byte} < 9'(NUM_REGS)) begin
                                        ptr   <= rx_byte[PTR_W-1:0];
                                        state <= S_PTR_ACK;
                                    end else begin
                                        state <= S_IGNORE;
                                    end
                                end else begin
                                    bank[ptr] <= rx_byte;
                                    wr_valid  <= 1'b1;
                                    wr_addr   <= ptr;
                                    wr_data   <= rx_byte;
                                    ptr       <= ptr_inc;
                                    state     <= S_WR_ACK;
                                end
                            end
                        end
                    end
                    // First falling SCL starts the ACK, the second one ends it.
                    S_ADDR_ACK, S_PTR_ACK, S_WR_ACK: begin
                        if (scl_fall) begin
                            if (!ack_phase) begin
                                sda_oe    <= 1'b1;
                                ack_phase <= 1'b1;
                            end else if (state == S_ADDR_ACK && rw) begin
                                tx_sh   <= bank[ptr];
                                sda_oe  <= ~bank[ptr][7];
                                bit_cnt <= '0;
                                state   <= S_READ;
                            end else begin
                                sda_oe  <= 1'b0;
                                bit_cnt <= '0;
                                state   <= (state == S_ADDR_ACK) ? S_PTR : S_WRITE;
                            end
                        end
                    end
                    S_READ: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                sda_oe  <= 1'b0;
                                rd_more <= 1'b0;
                                state   <= S_RD_ACK;
                            end else begin
                                tx_sh  <= {tx_sh[6:0], 1'b0};
                                sda_oe <= ~tx_sh[6];
                            end
                        end
                    end
                    S_RD_ACK: begin
                        if (scl_rise) begin
                            if (!fsda) begin
                                ptr     <= ptr_inc;
                                rd_more <= 1'b1;
                            end else begin
                                state <= S_IGNORE;
                            end
                        end else if (scl_fall && rd_more) begin
                            tx_sh   <= bank[ptr];
                            sda_oe  <= ~bank[ptr][7];
                            bit_cnt <= '0;
                            state   <= S_READ;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // NOTE: host_data gets a default before the guarded read, so this block never infers a latch.
    always_comb begin
        host_data = '0;
        if (int'(host_addr) < NUM_REGS) host_data = bank[host_addr];
    end

endmodule
